// File: rtl/dma_storage_primitives.sv
// Storage primitives for the DMA datapath: show-ahead FIFO with pointer rollback,
// loadable up-counter and enable-gated register, plus a wrapper exposing one of each.

module fifo #(
    parameter int DATA       = 16,
    parameter int ADDR_SIZE  = 5,
    parameter int DIV_FACTOR = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fifo_enable,
    input  logic            fifo_wr_rd,
    input  logic            fifo_old_add_flag,
    input  logic [DATA-1:0] fifo_in,
    output logic [DATA-1:0] fifo_out,
    output logic            full,
    output logic            empty,
    output logic            empty_partial
);
    localparam int DEPTH = 1 << ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] FULL_OCC = {1'b1, {ADDR_SIZE{1'b0}}};
    localparam logic [ADDR_SIZE:0] THRESH   = FULL_OCC >> DIV_FACTOR;
    localparam logic [ADDR_SIZE:0] ONE      = {{ADDR_SIZE{1'b0}}, 1'b1};

    logic [DATA-1:0]    mem [DEPTH];
    logic [ADDR_SIZE:0] wr_ptr_reg;
    logic [ADDR_SIZE:0] rd_ptr_reg;
    logic [ADDR_SIZE:0] occupancy;
    logic               flag_reg;
    logic               write_fire;
    logic               read_fire;
    logic               rollback;

    assign occupancy     = wr_ptr_reg - rd_ptr_reg;
    assign full          = (occupancy == FULL_OCC);
    assign empty         = (occupancy == '0);
    assign empty_partial = (occupancy <= THRESH);
    assign fifo_out      = mem[rd_ptr_reg[ADDR_SIZE-1:0]];

    // The rollback flag blocks transfers for as long as it is held high.
    assign rollback   = fifo_old_add_flag && !flag_reg;
    assign write_fire = !fifo_old_add_flag && fifo_enable && fifo_wr_rd && !full;
    assign read_fire  = !fifo_old_add_flag && fifo_enable && !fifo_wr_rd && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            flag_reg   <= 1'b0;
        end else begin
            flag_reg <= fifo_old_add_flag;
            if (rollback) begin
                if (fifo_wr_rd && !empty)
                    wr_ptr_reg <= wr_ptr_reg - ONE;
                else if (!fifo_wr_rd && !full)
                    rd_ptr_reg <= rd_ptr_reg - ONE;
            end else if (write_fire) begin
                wr_ptr_reg <= wr_ptr_reg + ONE;
            end else if (read_fire) begin
                rd_ptr_reg <= rd_ptr_reg + ONE;
            end
        end
    end

    // Storage is cleared by reset, so each entry is its own resettable register.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    mem[gi] <= '0;
                else if (write_fire && (wr_ptr_reg[ADDR_SIZE-1:0] == ADDR_SIZE'(gi)))
                    mem[gi] <= fifo_in;
            end
        end
    endgenerate
endmodule

module counter #(
    parameter int L = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cnt_en,
    input  logic         load,
    input  logic [L-1:0] data_in,
    output logic [L-1:0] cnt,
    output logic         end_cnt
);
    localparam logic [L-1:0] ONE = {{(L-1){1'b0}}, 1'b1};

    assign end_cnt = &cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (cnt_en)
            cnt <= load ? data_in : cnt + ONE;
    end
endmodule

module register #(
    parameter int REG_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 reg_en,
    input  logic [REG_DEPTH-1:0] data_in,
    output logic [REG_DEPTH-1:0] data_out
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            data_out <= '0;
        else if (reg_en)
            data_out <= data_in;
    end
endmodule

module dma_storage_primitives #(
    parameter int DATA       = 16,
    parameter int ADDR_SIZE  = 5,
    parameter int DIV_FACTOR = 3,
    parameter int L          = 15,
    parameter int REG_DEPTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_enable,
    input  logic                 fifo_wr_rd,
    input  logic                 fifo_old_add_flag,
    input  logic [DATA-1:0]      fifo_in,
    output logic [DATA-1:0]      fifo_out,
    output logic                 full,
    output logic                 empty,
    output logic                 empty_partial,
    input  logic                 cnt_en,
    input  logic                 load,
    input  logic [L-1:0]         cnt_data_in,
    output logic [L-1:0]         cnt,
    output logic                 end_cnt,
    input  logic                 reg_en,
    input  logic [REG_DEPTH-1:0] reg_data_in,
    output logic [REG_DEPTH-1:0] reg_data_out
);
    fifo #(.DATA(DATA), .ADDR_SIZE(ADDR_SIZE), .DIV_FACTOR(DIV_FACTOR)) u_fifo (
        .clk(clk), .rst(rst),
        .fifo_enable(fifo_enable), .fifo_wr_rd(fifo_wr_rd),
        .fifo_old_add_flag(fifo_old_add_flag), .fifo_in(fifo_in),
        .fifo_out(fifo_out), .full(full), .empty(empty), .empty_partial(empty_partial)
    );

    counter #(.L(L)) u_counter (
        .clk(clk), .rst(rst), .cnt_en(cnt_en), .load(load),
        .data_in(cnt_data_in), .cnt(cnt), .end_cnt(end_cnt)
    );

    register #(.REG_DEPTH(REG_DEPTH)) u_register (
        .clk(clk), .rst(rst), .reg_en(reg_en),
        .data_in(reg_data_in), .data_out(reg_data_out)
    );
endmodule

// File: tb/tb_dma_storage_primitives.sv
// Directed test of the DMA storage primitives: register, counter, FIFO fill/drain and rollback.

module tb_dma_storage_primitives;
    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_enable, fifo_wr_rd, fifo_old_add_flag;
    logic [15:0] fifo_in, fifo_out;
    logic        full, empty, empty_partial;
    logic        cnt_en, load;
    logic [14:0] cnt_data_in, cnt;
    logic        end_cnt;
    logic        reg_en;
    logic [15:0] reg_data_in, reg_data_out;

    int n_assert = 0;
    int n_fail   = 0;

    dma_storage_primitives dut (
        .clk(clk), .rst(rst),
        .fifo_enable(fifo_enable), .fifo_wr_rd(fifo_wr_rd),
        .fifo_old_add_flag(fifo_old_add_flag), .fifo_in(fifo_in),
        .fifo_out(fifo_out), .full(full), .empty(empty), .empty_partial(empty_partial),
        .cnt_en(cnt_en), .load(load), .cnt_data_in(cnt_data_in),
        .cnt(cnt), .end_cnt(end_cnt),
        .reg_en(reg_en), .reg_data_in(reg_data_in), .reg_data_out(reg_data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fifo_idle();
        fifo_enable = 1'b0;
        fifo_wr_rd = 1'b0;
        fifo_old_add_flag = 1'b0;
    endtask

    task automatic fifo_write(input logic [15:0] d);
        fifo_enable = 1'b1;
        fifo_wr_rd = 1'b1;
        fifo_in = d;
        step();
        fifo_idle();
    endtask

    task automatic fifo_read();
        fifo_enable = 1'b1;
        fifo_wr_rd = 1'b0;
        step();
        fifo_idle();
    endtask

    initial begin
        rst = 1'b1;
        fifo_idle();
        fifo_in = '0;
        cnt_en = 1'b0; load = 1'b0; cnt_data_in = '0;
        reg_en = 1'b0; reg_data_in = '0;
        step(); step();
        chk("rst_reg", reg_data_out, 32'h0);
        chk("rst_cnt", cnt, 32'h0);
        chk("rst_end_cnt", end_cnt, 32'h0);
        chk("rst_fifo_out", fifo_out, 32'h0);
        chk("rst_empty", empty, 32'h1);
        chk("rst_full", full, 32'h0);
        chk("rst_empty_partial", empty_partial, 32'h1);
        rst = 1'b0;
        step();

        // Register load, hold, async clear
        reg_en = 1'b1; reg_data_in = 16'h1234;
        step();
        chk("reg_load", reg_data_out, 32'h1234);
        reg_en = 1'b0; reg_data_in = 16'hFFFF;
        step();
        chk("reg_hold", reg_data_out, 32'h1234);
        rst = 1'b1;
        #2;
        chk("reg_async_rst", reg_data_out, 32'h0);
        rst = 1'b0;
        step();

        // Counter load, count to terminal value, wrap
        cnt_en = 1'b1; load = 1'b1; cnt_data_in = 15'h7FFD;
        step();
        chk("cnt_load_7ffd", cnt, 32'h7FFD);
        chk("end_cnt_7ffd", end_cnt, 32'h0);
        load = 1'b0;
        step();
        chk("cnt_7ffe", cnt, 32'h7FFE);
        step();
        chk("cnt_7fff", cnt, 32'h7FFF);
        chk("end_cnt_7fff", end_cnt, 32'h1);
        step();
        chk("cnt_wrap", cnt, 32'h0);
        chk("end_cnt_wrap", end_cnt, 32'h0);
        cnt_en = 1'b0; load = 1'b1; cnt_data_in = 15'd5;
        step();
        chk("cnt_load_no_en", cnt, 32'h0);
        cnt_en = 1'b1;
        step();
        chk("cnt_load_5", cnt, 32'h5);
        cnt_en = 1'b0; load = 1'b0;

        // FIFO fill with 1..32, then an extra write that must be dropped
        for (int i = 1; i <= 32; i++) begin
            fifo_write(16'(i));
            chk($sformatf("fill_out_%0d", i), fifo_out, 32'h1);
            chk($sformatf("fill_full_%0d", i), full, (i == 32) ? 32'h1 : 32'h0);
            chk($sformatf("fill_empty_partial_%0d", i), empty_partial, (i <= 4) ? 32'h1 : 32'h0);
        end
        chk("fill_empty", empty, 32'h0);
        fifo_write(16'h0099);
        chk("overflow_full", full, 32'h1);
        chk("overflow_out", fifo_out, 32'h1);

        // Drain in order; occupancy after read j is 32-j
        for (int j = 1; j <= 32; j++) begin
            chk($sformatf("drain_out_%0d", j), fifo_out, 32'(j));
            fifo_read();
            chk($sformatf("drain_empty_partial_%0d", j), empty_partial, ((32 - j) <= 4) ? 32'h1 : 32'h0);
            chk($sformatf("drain_empty_%0d", j), empty, (j == 32) ? 32'h1 : 32'h0);
            chk($sformatf("drain_full_%0d", j), full, 32'h0);
        end
        fifo_read();
        chk("underflow_empty", empty, 32'h1);
        chk("underflow_full", full, 32'h0);
        fifo_write(16'h0007);
        chk("after_underflow_out", fifo_out, 32'h7);
        chk("after_underflow_empty", empty, 32'h0);
        fifo_read();
        chk("after_underflow_drained", empty, 32'h1);

        // Rollback in write mode: A,B,C then hold flag 3 cycles with enable high
        fifo_write(16'h000A);
        fifo_write(16'h000B);
        fifo_write(16'h000C);
        fifo_old_add_flag = 1'b1; fifo_wr_rd = 1'b1; fifo_enable = 1'b1; fifo_in = 16'h00EE;
        step(); step(); step();
        fifo_idle();
        chk("wr_rollback_out", fifo_out, 32'hA);
        fifo_write(16'h000D);
        chk("wr_rb_read_a", fifo_out, 32'hA);
        fifo_read();
        chk("wr_rb_read_b", fifo_out, 32'hB);
        fifo_read();
        chk("wr_rb_read_d", fifo_out, 32'hD);
        chk("wr_rb_not_empty", empty, 32'h0);
        fifo_read();
        chk("wr_rb_empty", empty, 32'h1);

        // Rollback in read mode: read A, then hold flag 2 cycles with enable high
        fifo_write(16'h00A1);
        fifo_write(16'h00B2);
        fifo_read();
        chk("rd_rb_after_read", fifo_out, 32'hB2);
        fifo_old_add_flag = 1'b1; fifo_wr_rd = 1'b0; fifo_enable = 1'b1;
        step();
        chk("rd_rb_cycle1", fifo_out, 32'hA1);
        step();
        chk("rd_rb_cycle2", fifo_out, 32'hA1);
        fifo_idle();
        fifo_read();
        chk("rd_rb_next_b", fifo_out, 32'hB2);
        chk("rd_rb_not_empty", empty, 32'h0);
        fifo_read();
        chk("rd_rb_empty", empty, 32'h1);

        // Mid-operation reset discards FIFO content and count immediately
        cnt_en = 1'b1;
        fifo_write(16'h0055);
        cnt_en = 1'b0;
        chk("pre_rst_out", fifo_out, 32'h55);
        chk("pre_rst_cnt", cnt, 32'h6);
        rst = 1'b1;
        #2;
        chk("mid_rst_empty", empty, 32'h1);
        chk("mid_rst_out", fifo_out, 32'h0);
        chk("mid_rst_cnt", cnt, 32'h0);
        rst = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
